avalon_ram_ws: RTL and testbench
================================

Name: avalon_ram_ws

Overview:
Parametrised Avalon-MM slave word memory serving as the CPU test-harness RAM. It is the next generation of the testbench RAM model.
- Configurable depth, base address, and separate read/write wait-state counts.
- Full byte-enable writes.
- Priority program-load port for preloading instructions.
- Error flagging for misaligned, out-of-range and illegal accesses.
It sits between top_level_cpu's bus master and the testbench stimulus.

Parameters:
BASE_ADDR, 32'h00000000, byte address of word 0
DEPTH_WORDS, 256, number of 32-bit words (power of two, ≥4)
READ_WAIT, 1, cycles waitrequest is held high before a read completes (0..15)
WRITE_WAIT, 0, cycles waitrequest is held high before a write completes (0..15)
CLEAR_ON_RESET, 1, 1 = all words zeroed on reset; 0 = contents retained

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
address  in  32  Avalon byte address from master
write  in  1  write request
read  in  1  read request
waitrequest  out  1  slave stall, combinational
writedata  in  32  write data
byteenable  in  4  byte lanes; bit0 = writedata[7:0]
readdata  out  32  read data, valid when read=1 and waitrequest=0
load_en  in  1  program-load strobe, priority over bus
load_addr  in  32  byte address for load
load_data  in  32  full word written on load
access_error  out  1  one-cycle pulse on a faulted access
rd_count  out  16  completed reads, wraps at 16'hFFFF→0
wr_count  out  16  completed writes, wraps

Behaviour:
- Single clock, clk. reset is synchronous and active-high.
- Reset values: waitrequest=0, readdata=0, access_error=0, rd_count=0, wr_count=0. Wait counter and FSM return to IDLE. If CLEAR_ON_RESET=1, all words are zeroed.
- Reset mid-transaction aborts the access. No write commits in the reset cycle.
- FSM states:
  - IDLE→WAIT when read^write is asserted, no fault, WAIT>0 and load_en=0.
  - WAIT: counter increments each cycle; waitrequest=1 while counter<WAIT.
  - Completion cycle: waitrequest=0, then counter clears and FSM returns to IDLE.
  - WAIT=0: the access completes in the request cycle (waitrequest never high).
- Master must hold address/data/byteenable stable while waitrequest=1. If the request drops mid-WAIT, return to IDLE with no side effects.
- Reads: readdata is the combinational word at index ((address-BASE_ADDR)>>2) during the completion cycle, otherwise 0. rd_count increments on the completion edge.
- Writes: at the completion edge each enabled byte lane updates; disabled lanes keep their old value. byteenable=0000 still completes and increments wr_count, with no data change.
- Faults complete immediately (waitrequest=0, readdata=0, no memory change, no count increment) and pulse access_error for that cycle:
  - address[1:0]≠0.
  - address<BASE_ADDR or address≥BASE_ADDR+4*DEPTH_WORDS.
  - read&write both high.
- Load port: while load_en=1, waitrequest is forced to 1 for any bus request and the wait counter freezes. load_data is written to word (load_addr-BASE_ADDR)>>2 each edge.
- A misaligned or out-of-range load is dropped and pulses access_error.
- A load and a bus write to the same word cannot collide, because the bus stalls while load_en=1.
- Counter increments wrap modulo 2^16.

Test Plan:
- Reset with CLEAR_ON_RESET=1, then read 0x10 with READ_WAIT=1 → waitrequest high for exactly 1 cycle, readdata=0, rd_count=1.
- Load 0x04←240A0001 and 0x08←240B0007 via load_en, then read both (READ_WAIT=3) → 3 stall cycles each, data matches, access_error never set.
- Write 0xAABBCCDD to 0x20 with be=1111, then 0x11223344 with be=0101, then read → 0xAA22CC44, wr_count=2.
- Assert read with load_en=1 for 4 cycles → waitrequest=1 throughout; the read completes READ_WAIT cycles after load_en falls.
- Faults: read 0x06, read BASE+4*DEPTH, and read&write together → each gives one access_error pulse, waitrequest=0, readdata=0, counts unchanged.
- Assert reset during the 2nd wait cycle of a write with WRITE_WAIT=3 → target word unchanged, waitrequest=0 and wr_count=0 on the next cycle.

Source files
------------

// File: rtl/avalon_ram_ws.sv
// Avalon-MM slave word memory for the CPU test harness: byte-enable writes,
// programmable read/write wait states, priority program-load port, fault flagging.
module avalon_ram_ws #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter int unsigned READ_WAIT      = 1,
    parameter int unsigned WRITE_WAIT     = 0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        access_error,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [33:0] LIMIT   = {2'b00, BASE_ADDR} + 34'(DEPTH_WORDS) * 34'd4;
    localparam logic [4:0]  RD_WAIT = 5'(READ_WAIT);
    localparam logic [4:0]  WR_WAIT = 5'(WRITE_WAIT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state, state_next;
    logic [4:0]  cnt, cnt_next;
    logic        bus_req, single_req, is_wr;
    logic        bus_fault, valid_req, done;
    logic        rd_done, wr_done;
    logic        load_ok, load_fault;
    logic [4:0]  cur_wait;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({2'b00, a} < LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    always_comb begin
        bus_req    = read | write;
        single_req = read ^ write;
        is_wr      = write & ~read;
        cur_wait   = is_wr ? WR_WAIT : RD_WAIT;
        // The load port owns the memory: bus requests are neither faulted nor served.
        bus_fault  = bus_req & ~load_en & (~single_req | ~addr_ok(address));
        valid_req  = single_req & ~load_en & addr_ok(address);
        done       = valid_req & (cnt >= cur_wait);
        rd_done    = done & read;
        wr_done    = done & write;
        load_ok    = load_en & addr_ok(load_addr);
        load_fault = load_en & ~addr_ok(load_addr);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!load_en) begin
            case (state)
                ST_IDLE: begin
                    if (valid_req && !done) begin
                        state_next = ST_WAIT;
                        cnt_next   = cnt + 5'd1;
                    end
                end
                ST_WAIT: begin
                    if (!valid_req || done) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 5'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        waitrequest  = ~reset & ((bus_req & load_en) | (valid_req & ~done));
        readdata     = (~reset & rd_done) ? mem[word_idx(address)] : '0;
        access_error = ~reset & (bus_fault | load_fault);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_done) rd_count <= rd_count + 16'd1;
            if (wr_done) wr_count <= wr_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
            end
        end else if (load_ok) begin
            mem[word_idx(load_addr)] <= load_data;
        end else if (wr_done) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byteenable[b]) mem[word_idx(address)][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_avalon_ram_ws.sv
// Scoreboard bench for avalon_ram_ws: driver pushes predicted completions,
// monitor pops them whenever a bus access completes.
module tb_avalon_ram_ws;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 64;
    localparam int          RW    = 2;
    localparam int          WW    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        waitrequest;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        access_error;
    logic [15:0] rd_count, wr_count;

    avalon_ram_ws #(
        .BASE_ADDR(BASE),
        .DEPTH_WORDS(DEPTH),
        .READ_WAIT(RW),
        .WRITE_WAIT(WW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .access_error(access_error),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          stalls;
        int          rdc;
        int          wrc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [DEPTH];
    int          m_rd = 0;
    int          m_wr = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ok(input logic [31:0] a);
        longint ua = longint'(a);
        return (ua % 4 == 0) && (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_rd = 0;
        m_wr = 0;
    endtask

    // Predicted completion for a read or write issued now; model updated immediately.
    task automatic predict(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, input int extra);
        exp_t e;
        bit fault = (rd && wr) || !m_ok(a);
        e.err    = fault;
        e.stalls = fault ? 0 : (extra + (wr ? WW : RW));
        e.rdata  = (!fault && rd) ? m_mem[m_idx(a)] : 32'h0;
        e.rdc    = m_rd;
        e.wrc    = m_wr;
        sb.push_back(e);
        if (!fault && rd) m_rd++;
        if (!fault && wr) begin
            m_wr++;
            for (int b = 0; b < 4; b++)
                if (be[b]) m_mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic finish_bus();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (!waitrequest) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: got no completion expected one within 40 cycles, addr %h", address);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        @(posedge clk); #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_bus(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        predict(rd, wr, a, d, be, 0);
        address = a; writedata = d; byteenable = be;
        read = rd; write = wr;
        finish_bus();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        check("load_err", {31'b0, access_error}, {31'b0, !m_ok(a)});
        check("load_wreq", {31'b0, waitrequest}, 32'h0);
        @(posedge clk); #1;
        load_en = 1'b0;
        if (m_ok(a)) m_mem[m_idx(a)] = d;
    endtask

    // Monitor: counts stall cycles of the current request and scores each completion.
    initial begin : monitor
        int stall = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset || !(read || write)) begin
                stall = 0;
            end else if (waitrequest) begin
                stall++;
            end else begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got completion at %h expected none", address);
                end else begin
                    e = sb.pop_front();
                    check("rdata",   readdata,               e.rdata);
                    check("err",     {31'b0, access_error},  {31'b0, e.err});
                    check("stalls",  stall,                  e.stalls);
                    check("rd_cnt",  {16'b0, rd_count},      32'(e.rdc % 65536));
                    check("wr_cnt",  {16'b0, wr_count},      32'(e.wrc % 65536));
                end
                stall = 0;
            end
        end
    end

    initial begin : stim
        m_reset();
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_wreq", {31'b0, waitrequest}, 32'h0);
        check("rst_rdata", readdata, 32'h0);
        check("rst_err", {31'b0, access_error}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdcnt", {16'b0, rd_count}, 32'h0);
        check("rst_wrcnt", {16'b0, wr_count}, 32'h0);
        @(posedge clk); #1;

        do_bus(1'b1, 1'b0, BASE + 32'h10, '0, 4'h0);

        do_load(BASE + 32'h04, 32'h240A_0001);
        do_load(BASE + 32'h08, 32'h240B_0007);
        do_bus(1'b1, 1'b0, BASE + 32'h04, '0, 4'h0);
        do_bus(1'b1, 1'b0, BASE + 32'h08, '0, 4'h0);

        do_bus(1'b0, 1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b1111);
        do_bus(1'b0, 1'b1, BASE + 32'h20, 32'h1122_3344, 4'b0101);
        do_bus(1'b0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000);
        do_bus(1'b1, 1'b0, BASE + 32'h20, '0, 4'h0);

        // Read held while load_en is high for 4 cycles.
        for (int i = 0; i < 4; i++) m_mem[m_idx(BASE + 32'h0C)] = 32'h5A5A_0000 + 32'(i);
        predict(1'b1, 1'b0, BASE + 32'h0C, '0, 4'h0, 4);
        address = BASE + 32'h0C; read = 1'b1;
        load_en = 1'b1; load_addr = BASE + 32'h0C;
        for (int i = 0; i < 4; i++) begin
            load_data = 32'h5A5A_0000 + 32'(i);
            @(negedge clk);
            check("ld_stall", {31'b0, waitrequest}, 32'h1);
            check("ld_err", {31'b0, access_error}, 32'h0);
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        finish_bus();

        do_bus(1'b1, 1'b0, BASE + 32'h06, '0, 4'h0);
        do_bus(1'b1, 1'b0, BASE + 32'(4 * DEPTH), '0, 4'h0);
        do_bus(1'b1, 1'b0, BASE - 32'h4, '0, 4'h0);
        do_bus(1'b1, 1'b1, BASE + 32'h04, 32'hDEAD_BEEF, 4'hF);
        do_bus(1'b0, 1'b1, BASE + 32'h22, 32'hDEAD_BEEF, 4'hF);
        do_load(BASE + 32'h0D, 32'h1234_5678);
        do_load(BASE + 32'(4 * DEPTH), 32'h1234_5678);

        for (int i = 0; i < 150; i++) begin
            int unsigned k;
            int unsigned op;
            logic [31:0] a;
            logic [31:0] d;
            k  = $urandom_range(0, 11);
            op = $urandom_range(0, 9);
            d  = $urandom;
            a  = BASE + 32'(4 * $urandom_range(0, 7));
            if (k == 0) a = a + 32'($urandom_range(1, 3));
            else if (k == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            else if (k == 2) a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (k == 3) a = BASE + 32'(4 * (DEPTH - 1));
            if (op < 4) do_bus(1'b1, 1'b0, a, '0, 4'h0);
            else if (op < 8) do_bus(1'b0, 1'b1, a, d, 4'($urandom_range(0, 15)));
            else if (op == 8) do_load(a, d);
            else do_bus(1'b1, 1'b1, a, d, 4'hF);
        end

        @(negedge clk);
        check("final_rdcnt", {16'b0, rd_count}, 32'(m_rd % 65536));
        check("final_wrcnt", {16'b0, wr_count}, 32'(m_wr % 65536));
        @(posedge clk); #1;

        // Reset during the second wait cycle of a write aborts it.
        address = BASE + 32'h30; writedata = 32'hCAFE_F00D; byteenable = 4'hF;
        write = 1'b1;
        @(negedge clk);
        check("abort_wreq0", {31'b0, waitrequest}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_rst_wreq", {31'b0, waitrequest}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        write = 1'b0;
        m_reset();
        @(negedge clk);
        check("abort_wreq", {31'b0, waitrequest}, 32'h0);
        check("abort_wrcnt", {16'b0, wr_count}, 32'h0);
        check("abort_rdcnt", {16'b0, rd_count}, 32'h0);
        @(posedge clk); #1;
        do_bus(1'b1, 1'b0, BASE + 32'h30, '0, 4'h0);
        do_bus(1'b1, 1'b0, BASE + 32'h20, '0, 4'h0);

        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        check("end_rdcnt", {16'b0, rd_count}, 32'(m_rd % 65536));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
